// File: rtl/clk_div_monitor.sv
`default_nettype none
// clk_div_monitor: synchronises the divided clock, emits per-edge ticks, measures its period, flags stalls.
// Optional min/max period tracking is enabled by defining CLK_DIV_MONITOR_MINMAX_EN.
module clk_div_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_div,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] timeout,
  output logic                   tick,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   period_valid,
  output logic                   stalled
`ifdef CLK_DIV_MONITOR_MINMAX_EN
  ,
  output logic [COUNT_WIDTH-1:0] period_min,
  output logic [COUNT_WIDTH-1:0] period_max
`endif
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      clk_div_monitor_sync_stages_below_2 u_param_error ();
    end
    if (COUNT_WIDTH < 2) begin : g_bad_count_width
      clk_div_monitor_count_width_below_2 u_param_error ();
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2,
    STALLED = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   rise;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] elapsed;
  logic                   stall_hit;
  logic                   measure_done;

  assign rise         = sync[SYNC_STAGES-1] & ~prev;
  assign elapsed      = (&count) ? count : count + 1'b1;
  assign stall_hit    = (timeout != '0) && (elapsed == timeout);
  assign measure_done = enable && (state == MEASURE) && rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      prev <= 1'b0;
      tick <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], clk_div};
      prev <= sync[SYNC_STAGES-1];
      tick <= rise & enable;
    end
  end

  // A rise always takes priority over a coincident timeout expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      count        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        count   <= '0;
        stalled <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            count   <= '0;
            stalled <= 1'b0;
            state   <= ACQUIRE;
          end
          ACQUIRE: begin
            if (rise) begin
              state <= MEASURE;
              count <= '0;
            end else if (stall_hit) begin
              state   <= STALLED;
              stalled <= 1'b1;
            end else begin
              count <= elapsed;
            end
          end
          MEASURE: begin
            if (rise) begin
              period       <= elapsed;
              period_valid <= 1'b1;
              count        <= '0;
            end else if (stall_hit) begin
              state   <= STALLED;
              stalled <= 1'b1;
            end else begin
              count <= elapsed;
            end
          end
          STALLED: begin
            // The interval following a stall only re-establishes the reference edge.
            if (rise) begin
              state   <= MEASURE;
              count   <= '0;
              stalled <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            count   <= '0;
            stalled <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CLK_DIV_MONITOR_MINMAX_EN
  logic enable_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_d   <= 1'b0;
      period_min <= '1;
      period_max <= '0;
    end else begin
      enable_d <= enable;
      if (enable && !enable_d) begin
        period_min <= '1;
        period_max <= '0;
      end else if (measure_done) begin
        if (elapsed < period_min) period_min <= elapsed;
        if (elapsed > period_max) period_max <= elapsed;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for clk_div_monitor: table-driven scenarios, corner sequences and randomized runs vs. an edge-index model.
module tb_clk_div_monitor;
  localparam int W  = 16;
  localparam int W4 = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_div = 1'b0;
  logic          enable = 1'b0;
  logic [W-1:0]  timeout = '0;
  logic          tick, period_valid, stalled;
  logic [W-1:0]  period;
  logic          tick4, pv4, st4;
  logic [W4-1:0] period4;
`ifdef CLK_DIV_MONITOR_MINMAX_EN
  logic [W-1:0]  pmin, pmax;
  logic [W4-1:0] pmin4, pmax4;
`endif

  always #5 clk = ~clk;

  clk_div_monitor #(.SYNC_STAGES(2), .COUNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .enable(enable), .timeout(timeout),
    .tick(tick), .period(period), .period_valid(period_valid), .stalled(stalled)
`ifdef CLK_DIV_MONITOR_MINMAX_EN
    , .period_min(pmin), .period_max(pmax)
`endif
  );

  clk_div_monitor #(.SYNC_STAGES(2), .COUNT_WIDTH(W4)) dut4 (
    .clk(clk), .rst(rst), .clk_div(clk_div), .enable(enable), .timeout(timeout[W4-1:0]),
    .tick(tick4), .period(period4), .period_valid(pv4), .stalled(st4)
`ifdef CLK_DIV_MONITOR_MINMAX_EN
    , .period_min(pmin4), .period_max(pmax4)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: everything is expressed as clk edge indices.
  int n = 0;
  int ref_edge = 0;
  bit active, armed, m_stalled, m_pv, m_tick, prev_en;
  int raw_period, m_min, m_max;
  bit s[$];
  bit chk4 = 0;

  // Stimulus and observation state.
  bit cdv = 0;
  int phase = 0;
  int tick_edges[$];
  int pv_edges[$];
  int last_tick_edge, stall_rise_edge, stall_fall_edge;
  bit obs_st, any_stall;

  function automatic logic [W-1:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [W4-1:0] sat4(input int v);
    return (v > 15) ? 4'hF : 4'(v);
  endfunction

  task automatic model_reset();
    active = 0; armed = 0; m_stalled = 0; m_pv = 0; m_tick = 0; prev_en = 0;
    raw_period = 0; m_min = 1 << 20; m_max = 0;
    s.delete();
    repeat (3) s.push_back(1'b0);
  endtask

  task automatic model_edge(input bit cd, input bit en, input int to);
    bit rise;
    int el;
    n++;
    rise = s[1] && !s[2];
    s.push_front(cd);
    void'(s.pop_back());
    m_tick = rise && en;
    m_pv = 0;
    if (en && !prev_en) begin
      m_min = 1 << 20;
      m_max = 0;
    end
    prev_en = en;
    if (!en) begin
      active = 0; m_stalled = 0;
    end else if (!active) begin
      active = 1; armed = 0; m_stalled = 0; ref_edge = n;
    end else if (m_stalled) begin
      if (rise) begin m_stalled = 0; armed = 1; ref_edge = n; end
    end else begin
      el = n - ref_edge;
      if (rise) begin
        if (armed) begin
          raw_period = el; m_pv = 1;
          if (el < m_min) m_min = el;
          if (el > m_max) m_max = el;
        end
        armed = 1; ref_edge = n;
      end else if (to != 0 && int'(sat16(el)) == to) begin
        m_stalled = 1;
      end
    end
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_edge();
    tests++;
    if ({tick, period_valid, stalled, period} !== {m_tick, m_pv, m_stalled, sat16(raw_period)}) begin
      fails++;
      $display("FAIL edge %0d outputs: got tick/pv/stall/period=%b/%b/%b/%0d want %b/%b/%b/%0d",
               n, tick, period_valid, stalled, period, m_tick, m_pv, m_stalled, sat16(raw_period));
    end
`ifdef CLK_DIV_MONITOR_MINMAX_EN
    tests++;
    if ({pmin, pmax} !== {sat16(m_min), sat16(m_max)}) begin
      fails++;
      $display("FAIL edge %0d minmax: got %0d/%0d want %0d/%0d", n, pmin, pmax, sat16(m_min), sat16(m_max));
    end
`endif
    if (chk4) begin
      tests++;
      if ({tick4, pv4, st4, period4} !== {m_tick, m_pv, m_stalled, sat4(raw_period)}) begin
        fails++;
        $display("FAIL edge %0d width4: got tick/pv/stall/period=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 n, tick4, pv4, st4, period4, m_tick, m_pv, m_stalled, sat4(raw_period));
      end
    end
  endtask

  task automatic step(input logic cd);
    clk_div = cd;
    @(posedge clk);
    model_edge(cd, enable, int'(timeout));
    #1;
    check_edge();
    if (tick) begin tick_edges.push_back(n); last_tick_edge = n; end
    if (period_valid) pv_edges.push_back(n);
    if (stalled) any_stall = 1;
    if (stalled && !obs_st) stall_rise_edge = n;
    if (!stalled && obs_st) stall_fall_edge = n;
    obs_st = stalled;
  endtask

  task automatic run_div(input int cycles, input int h);
    for (int i = 0; i < cycles; i++) begin
      step(cdv);
      phase++;
      if (phase >= h) begin cdv = ~cdv; phase = 0; end
    end
  endtask

  // Asserts reset between clock edges and checks outputs clear without any edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    clk_div = 1'b0;
    #1;
    tests++;
    if ({tick, period_valid, stalled, period} !== '0) begin
      fails++;
      $display("FAIL async_reset: got tick/pv/stall/period=%b/%b/%b/%0d want 0/0/0/0",
               tick, period_valid, stalled, period);
    end
`ifdef CLK_DIV_MONITOR_MINMAX_EN
    tests++;
    if ({pmin, pmax} !== {16'hFFFF, 16'h0000}) begin
      fails++;
      $display("FAIL async_reset minmax: got %0d/%0d want 65535/0", pmin, pmax);
    end
`endif
    model_reset();
    cdv = 0; phase = 0; obs_st = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_obs();
    tick_edges.delete();
    pv_edges.delete();
    any_stall = 0;
    stall_rise_edge = -1;
    stall_fall_edge = -1;
  endtask

  function automatic int qget(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  typedef struct {
    int          half;
    int          to;
    int          cycles;
    logic [15:0] exp_period;
    logic [3:0]  exp_p4;
    bit          use4;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{half: 4,  to: 0,  cycles: 80,  exp_period: 16'd8,  exp_p4: 4'd8,  use4: 1'b1};
    vecs[1] = '{half: 4,  to: 8,  cycles: 80,  exp_period: 16'd8,  exp_p4: 4'd8,  use4: 1'b0};
    vecs[2] = '{half: 3,  to: 0,  cycles: 80,  exp_period: 16'd6,  exp_p4: 4'd6,  use4: 1'b1};
    vecs[3] = '{half: 16, to: 0,  cycles: 200, exp_period: 16'd32, exp_p4: 4'd15, use4: 1'b1};
    vecs[4] = '{half: 5,  to: 11, cycles: 100, exp_period: 16'd10, exp_p4: 4'd10, use4: 1'b0};
    vecs[5] = '{half: 4,  to: 9,  cycles: 80,  exp_period: 16'd8,  exp_p4: 4'd8,  use4: 1'b0};

    model_reset();
    do_reset();

    for (int v = 0; v < 6; v++) begin
      enable = 1'b0;
      do_reset();
      timeout = 16'(vecs[v].to);
      chk4 = vecs[v].use4;
      clear_obs();
      enable = 1'b1;
      run_div(vecs[v].cycles, vecs[v].half);
      expect_int($sformatf("vec%0d period", v), int'(period), int'(vecs[v].exp_period));
      expect_int($sformatf("vec%0d stall_seen", v), int'(any_stall), 0);
      expect_int($sformatf("vec%0d first_valid_at_second_tick", v), qget(pv_edges, 0), qget(tick_edges, 1));
      if (vecs[v].use4)
        expect_int($sformatf("vec%0d period_w4", v), int'(period4), int'(vecs[v].exp_p4));
      chk4 = 0;
    end

    // Stall on a held-low divider, then recovery.
    enable = 1'b0;
    do_reset();
    timeout = 16'd20;
    enable = 1'b1;
    run_div(64, 4);
    clear_obs();
    cdv = 0; phase = 0;
    repeat (30) step(1'b0);
    expect_int("stall level", int'(stalled), 1);
    expect_int("stall edges after rise", stall_rise_edge - last_tick_edge + 1, 21);
    expect_int("stall valid count", pv_edges.size(), 0);
    clear_obs();
    run_div(40, 4);
    expect_int("stall drop at first tick", stall_fall_edge, qget(tick_edges, 0));
    expect_int("post-stall first valid", qget(pv_edges, 0), qget(tick_edges, 1));
    expect_int("post-stall period", int'(period), 8);

    // Asynchronous reset mid-measurement, then restart from IDLE.
    timeout = 16'd0;
    run_div(5, 4);
    do_reset();
    clear_obs();
    run_div(40, 4);
    expect_int("post-reset first valid", qget(pv_edges, 0), qget(tick_edges, 1));
    expect_int("post-reset period", int'(period), 8);

    // Enable gap: no valid, period retained, min/max reinitialised.
    enable = 1'b0;
    do_reset();
    enable = 1'b1;
    run_div(64, 4);
    clear_obs();
    enable = 1'b0;
    run_div(3, 4);
    enable = 1'b1;
    run_div(1, 4);
    expect_int("gap valid count", pv_edges.size(), 0);
    expect_int("gap period hold", int'(period), 8);
`ifdef CLK_DIV_MONITOR_MINMAX_EN
    expect_int("gap min reinit", int'(pmin), 65535);
    expect_int("gap max reinit", int'(pmax), 0);
`endif
    run_div(40, 4);
    expect_int("after gap period", int'(period), 8);
`ifdef CLK_DIV_MONITOR_MINMAX_EN
    expect_int("after gap min", int'(pmin), 8);
    expect_int("after gap max", int'(pmax), 8);
`endif

    // Randomized segments: divider rate, timeout, enable and holds all vary.
    for (int seg = 0; seg < 30; seg++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      timeout = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
      enable = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(10, 40)) step(1'b0);
        cdv = 0; phase = 0;
      end else begin
        run_div($urandom_range(20, 120), $urandom_range(2, 12));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Downstream consumer of the ripple clock divider output. It brings the asynchronous divided clock into the `clk` domain and turns each of its rising edges into a one-cycle `tick` enable. It also measures the divided period in `clk` cycles and flags a stalled divider. Used by the power-management and test logic to check divider health without clocking any logic on the divided clock.

Parameters:
SYNC_STAGES, 2, synchronizer depth for `clk_div`; a value below 2 is an elaboration error (instantiate a non-existent module, as for other illegal parameters).
COUNT_WIDTH, 16, width of the elapsed-cycle counter, `period` and `timeout`; a value below 2 is an elaboration error.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-low reset.
clk_div  input  1  divided clock from the divider; asynchronous to `clk`.
enable  input  1  monitor enable; synchronous to `clk`.
timeout  input  COUNT_WIDTH  stall threshold in `clk` cycles; 0 disables stall detection.
tick  output  1  one-cycle pulse per detected `clk_div` rising edge.
period  output  COUNT_WIDTH  last measured period in `clk` cycles.
period_valid  output  1  one-cycle pulse when `period` is updated.
stalled  output  1  level; the divider has stalled.

Behaviour:
- Reset (rst=0, no clock needed):
  - sync chain, edge register, count, period, tick, period_valid and stalled all go to 0;
  - FSM goes to IDLE.
- Synchronizer and edge detection:
  - SYNC_STAGES flops, then one edge register `prev`.
  - `rise` = sync_out & ~prev, evaluated combinationally.
  - `tick` is `rise` registered, gated by enable.
  - Latency from `clk_div` rising to `tick` high is SYNC_STAGES+1 clk edges.
- `elapsed` is defined as count+1, saturating at 2^COUNT_WIDTH-1.
- FSM states: IDLE, ACQUIRE, MEASURE, STALLED.
- IDLE:
  - count=0, stalled=0, period holds its value.
  - enable=1 → ACQUIRE.
- ACQUIRE (waiting for the reference edge):
  - rise → MEASURE with count:=0, no period_valid.
  - No rise, timeout≠0 and elapsed==timeout → STALLED.
  - Otherwise count:=elapsed.
- MEASURE:
  - rise → period:=elapsed, period_valid=1 the next cycle, count:=0.
  - No rise, timeout≠0 and elapsed==timeout → STALLED, no period_valid.
  - Otherwise count:=elapsed.
- STALLED:
  - stalled=1 while in this state.
  - rise → MEASURE, count:=0; stalled drops on the next cycle.
  - The first interval after a stall is only a reference, so no period_valid is issued.
- enable=0 in any state → IDLE on the next edge. Any pending period_valid is suppressed; period is retained.
- A rise coinciding with elapsed==timeout: rise wins (valid period, no stall).
- Counter saturation: count sticks at all-ones; the reported period is then 2^COUNT_WIDTH-1.
- `timeout` is sampled every cycle; changing it mid-measurement takes effect immediately.
- Steady state: a divider of N stages yields period = 2^N exactly.

Optional Feature:
Macro: CLK_DIV_MONITOR_MINMAX_EN.
- Defined:
  - Adds outputs `period_min` and `period_max` (COUNT_WIDTH each).
  - Reset values: period_min = all-ones, period_max = 0.
  - Both update in the same cycle as `period` on every valid measurement.
  - Both reinitialise to the reset values on the cycle enable rises from 0 to 1.
- Undefined: the ports and their registers are absent; all other behaviour is identical.

Test Plan:
1. SYNC_STAGES=2, clk_div toggling every 4 clk (period 8), enable=1, timeout=0 → tick 3 edges after each clk_div rise; first period_valid at the second rise; period=8 on every subsequent valid; stalled stays 0.
2. Period 8 running, timeout=20, clk_div then held low → stalled=1 exactly 21 cycles after the last rise was detected, no period_valid. Restart toggling → stalled=0 one cycle after the first rise; next period_valid only at the second rise, with period=8.
3. Mid-MEASURE, rst pulsed low between clk edges → all outputs 0 immediately. After release, behaviour restarts from IDLE: first valid at the second rise.
4. COUNT_WIDTH=4, clk_div period 32 → period=15 (saturated) on each valid; no stall with timeout=0.
5. Period 8 running, enable dropped for 3 cycles then raised → no period_valid across the gap; period holds 8. With MINMAX_EN, period_min=all-ones and period_max=0 after re-enable, then both equal 8 after the next valid.
6. timeout=8, period 8 → every rise coincides with elapsed==8; period_valid each period with period=8; stalled never asserts.
